pipelined_ext_adder: RTL and testbench



---
 rtl/pipelined_ext_adder_pkg.sv | 22 ++
 rtl/pipelined_ext_adder_if.sv | 25 ++
 rtl/pipelined_ext_adder_chunk.sv | 73 +++++++
 rtl/pipelined_ext_adder.sv | 84 ++++++++
 tb/tb_pipelined_ext_adder.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_ext_adder_pkg.sv
// Shared constants and sizing helpers for the pipelined extend-and-add block.
// Stage count and per-stage chunk widths are derived here.
package pipelined_ext_adder_pkg;

    localparam int DEFAULT_CHUNK = 12;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    function automatic int chunk_width(input int k, input int a_w, input int chunk);
        int n;
        n = ceil_div(a_w, chunk);
        return (k == n - 1) ? a_w - (n - 1) * chunk : chunk;
    endfunction

endpackage

// File: rtl/pipelined_ext_adder_if.sv
// Input/output valid-ready bundle of the pipelined extend-and-add block.
// The producer/consumer side uses master; the adder uses slave.
interface pipelined_ext_adder_if #(
    parameter int A_WIDTH = 35,
    parameter int B_WIDTH = 31
);
    logic               in_valid;
    logic               in_ready;
    logic [A_WIDTH-1:0] in_a;
    logic [B_WIDTH-1:0] in_b;
    logic               op_sub;
    logic               out_valid;
    logic               out_ready;
    logic [A_WIDTH:0]   out_sum;

    modport master (
        output in_valid, in_a, in_b, op_sub, out_ready,
        input  in_ready, out_valid, out_sum
    );

    modport slave (
        input  in_valid, in_a, in_b, op_sub, out_ready,
        output in_ready, out_valid, out_sum
    );
endinterface

// File: rtl/pipelined_ext_adder_chunk.sv
// One carry-save-free pipeline stage: adds one chunk of A and Bx plus the
// incoming carry, forwarding untouched upper operand bits and finished low bits.
module adder_chunk_stage #(
    parameter  int W   = 12,
    parameter  int OFF = 0,
    parameter  int HI  = 35,
    localparam int REM = HI - W,
    localparam int IW  = 2 * HI + 1 + OFF,
    localparam int OW  = 2 * REM + 1 + OFF + W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          valid_i,
    input  logic [IW-1:0] data_i,
    output logic          valid_o,
    output logic [OW-1:0] data_o
);

    // Bundle layout, LSB first: done result bits, carry, Bx upper, A upper.
    logic [W-1:0]  a_c;
    logic [W-1:0]  b_c;
    logic [W:0]    sum;
    logic [OW-1:0] nxt;
    logic [OW-1:0] data_d;
    logic [OW-1:0] data_q;
    logic          valid_d;
    logic          valid_q;

    always_comb begin
        a_c = '0;
        b_c = '0;
        for (int i = 0; i < W; i++) begin
            a_c[i] = data_i[OFF + 1 + HI + i];
            b_c[i] = data_i[OFF + 1 + i];
        end
        sum = {1'b0, a_c} + {1'b0, b_c} + {{W{1'b0}}, data_i[OFF]};
    end

    always_comb begin
        nxt = '0;
        for (int i = 0; i < OFF; i++) begin
            nxt[i] = data_i[i];
        end
        for (int i = 0; i < W; i++) begin
            nxt[OFF + i] = sum[i];
        end
        nxt[OFF + W] = sum[W];
        for (int i = 0; i < REM; i++) begin
            nxt[OFF + W + 1 + i]       = data_i[OFF + 1 + W + i];
            nxt[OFF + W + 1 + REM + i] = data_i[OFF + 1 + HI + W + i];
        end
    end

    always_comb begin
        data_d  = en ? nxt : data_q;
        valid_d = en ? valid_i : valid_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/pipelined_ext_adder.sv
// Pipelined A + ext(B) / A - ext(B) with chunked carry propagation.
// All stages advance together whenever the output slot is free or drained.
module pipelined_ext_adder
    import pipelined_ext_adder_pkg::*;
#(
    parameter int A_WIDTH    = 35,
    parameter int B_WIDTH    = 31,
    parameter int CHUNK      = DEFAULT_CHUNK,
    parameter bit SIGN_EXT_B = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    pipelined_ext_adder_if.slave bus
);

    localparam int NSTAGES = ceil_div(A_WIDTH, CHUNK);

    if (B_WIDTH < 1 || B_WIDTH > A_WIDTH) begin : g_bad_width
        $error("pipelined_ext_adder: B_WIDTH must be within 1..A_WIDTH");
    end

    logic               adv;
    logic [A_WIDTH-1:0] b_ext;
    logic [A_WIDTH-1:0] b_x;
    op_e                op;

    if (B_WIDTH == A_WIDTH) begin : g_noext
        assign b_ext = bus.in_b;
    end else begin : g_ext
        logic fill;
        assign fill  = SIGN_EXT_B ? bus.in_b[B_WIDTH-1] : 1'b0;
        assign b_ext = {{(A_WIDTH - B_WIDTH){fill}}, bus.in_b};
    end

    always_comb begin
        op  = op_e'(bus.op_sub);
        b_x = (op == OP_SUB) ? ~b_ext : b_ext;
        adv = !bus.out_valid | bus.out_ready;
    end

    assign bus.in_ready = adv;

    for (genvar k = 0; k < NSTAGES; k++) begin : g_st
        localparam int OFF = k * CHUNK;
        localparam int W   = chunk_width(k, A_WIDTH, CHUNK);
        localparam int HI  = A_WIDTH - OFF;
        localparam int IW  = 2 * HI + 1 + OFF;
        localparam int OW  = 2 * (HI - W) + 1 + OFF + W;

        logic [IW-1:0] din;
        logic          vin;
        logic [OW-1:0] q;
        logic          vq;

        if (k == 0) begin : g_first
            // Subtraction carry-in rides in the carry slot of the bundle.
            assign din = {bus.in_a, b_x, bus.op_sub};
            assign vin = bus.in_valid;
        end else begin : g_next
            assign din = g_st[k-1].q;
            assign vin = g_st[k-1].vq;
        end

        adder_chunk_stage #(
            .W   (W),
            .OFF (OFF),
            .HI  (HI)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (adv),
            .valid_i (vin),
            .data_i  (din),
            .valid_o (vq),
            .data_o  (q)
        );

        if (k == NSTAGES - 1) begin : g_last
            assign bus.out_valid = vq;
            assign bus.out_sum   = q;
        end
    end

endmodule

// File: tb/tb_pipelined_ext_adder.sv
// Self-checking bench: three adder instances against a cycle-level reference.
// Covers default, sign-extending and single-stage configurations.
module tb_pipelined_ext_adder;

    localparam int LAT [3] = '{3, 3, 1};

    logic clk;
    logic rst_n;
    logic in_valid;
    logic [34:0] in_a;
    logic [30:0] in_b;
    logic op_sub;
    logic out_ready;

    int checks = 0;
    int errors = 0;

    pipelined_ext_adder_if #(.A_WIDTH(35), .B_WIDTH(31)) if0 ();
    pipelined_ext_adder_if #(.A_WIDTH(35), .B_WIDTH(31)) if1 ();
    pipelined_ext_adder_if #(.A_WIDTH(35), .B_WIDTH(31)) if2 ();

    pipelined_ext_adder #(
        .A_WIDTH(35), .B_WIDTH(31), .CHUNK(12), .SIGN_EXT_B(1'b0)
    ) u_main (.clk(clk), .rst_n(rst_n), .bus(if0));

    pipelined_ext_adder #(
        .A_WIDTH(35), .B_WIDTH(31), .CHUNK(12), .SIGN_EXT_B(1'b1)
    ) u_sext (.clk(clk), .rst_n(rst_n), .bus(if1));

    pipelined_ext_adder #(
        .A_WIDTH(35), .B_WIDTH(31), .CHUNK(40), .SIGN_EXT_B(1'b0)
    ) u_one (.clk(clk), .rst_n(rst_n), .bus(if2));

    assign if0.in_valid = in_valid;
    assign if0.in_a = in_a;
    assign if0.in_b = in_b;
    assign if0.op_sub = op_sub;
    assign if0.out_ready = out_ready;
    assign if1.in_valid = in_valid;
    assign if1.in_a = in_a;
    assign if1.in_b = in_b;
    assign if1.op_sub = op_sub;
    assign if1.out_ready = out_ready;
    assign if2.in_valid = in_valid;
    assign if2.in_a = in_a;
    assign if2.in_b = in_b;
    assign if2.op_sub = op_sub;
    assign if2.out_ready = out_ready;

    logic ov [3];
    logic ir [3];
    logic [35:0] os [3];
    assign ov[0] = if0.out_valid;
    assign ov[1] = if1.out_valid;
    assign ov[2] = if2.out_valid;
    assign ir[0] = if0.in_ready;
    assign ir[1] = if1.in_ready;
    assign ir[2] = if2.in_ready;
    assign os[0] = if0.out_sum;
    assign os[1] = if1.out_sum;
    assign os[2] = if2.out_sum;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a LAT-deep delay line of (valid, exact arithmetic result).
    bit mv [3][3];
    logic [35:0] ms [3][3];

    function automatic logic [35:0] ref_sum(input logic [34:0] a, input logic [30:0] b,
                                            input logic sub, input bit sext);
        logic [35:0] bx;
        bx = 36'(b);
        if (sext && b[30]) bx = bx + 36'h7_8000_0000;
        if (sub) return 36'(a) + 36'h8_0000_0000 - bx;
        return 36'(a) + bx;
    endfunction

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 3; d++)
            for (int s = 0; s < 3; s++) begin
                mv[d][s] = 1'b0;
                ms[d][s] = '0;
            end
    endtask

    task automatic cycle();
        bit adv [3];
        #1;
        for (int d = 0; d < 3; d++) begin
            adv[d] = !mv[d][LAT[d]-1] || out_ready;
            chk($sformatf("in_ready%0d", d), 36'(ir[d]), 36'(adv[d]));
        end
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            if (adv[d]) begin
                for (int s = LAT[d] - 1; s > 0; s--) begin
                    mv[d][s] = mv[d][s-1];
                    ms[d][s] = ms[d][s-1];
                end
                mv[d][0] = in_valid;
                ms[d][0] = ref_sum(in_a, in_b, op_sub, d == 1);
            end
        end
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("out_valid%0d", d), 36'(ov[d]), 36'(mv[d][LAT[d]-1]));
            if (mv[d][LAT[d]-1])
                chk($sformatf("out_sum%0d", d), os[d], ms[d][LAT[d]-1]);
        end
    endtask

    task automatic drive_rand();
        in_a = 35'({$urandom(), $urandom()});
        in_b = 31'($urandom());
        op_sub = 1'($urandom());
    endtask

    logic [35:0] got [$];
    logic [35:0] held;
    int idx;
    int stall_left;
    bit stall_started;
    bit acc;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        op_sub = 1'b0;
        out_ready = 1'b1;
        model_clear();

        // Reset with random inputs applied
        for (int n = 0; n < 3; n++) begin
            in_valid = 1'($urandom());
            out_ready = 1'($urandom());
            drive_rand();
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) begin
                chk("reset_valid", 36'(ov[d]), 36'd0);
                chk("reset_sum", os[d], 36'd0);
                chk("reset_ready", 36'(ir[d]), 36'd1);
            end
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) cycle();

        // Full carry ripple
        in_valid = 1'b1; in_a = 35'h7_FFFF_FFFF; in_b = 31'h1; op_sub = 1'b0;
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        chk("ripple_valid", 36'(ov[0]), 36'd1);
        chk("ripple_sum", os[0], 36'h8_0000_0000);

        // Subtract without borrow
        in_valid = 1'b1; in_a = 35'd100; in_b = 31'd1; op_sub = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        chk("sub_nb_sum", os[0], 36'h8_0000_0063);

        // Subtract with borrow
        in_valid = 1'b1; in_a = 35'd0; in_b = 31'd1; op_sub = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        chk("sub_b_sum", os[0], 36'h7_FFFF_FFFF);

        // Sign extension of a negative B
        in_valid = 1'b1; in_a = 35'd5; in_b = 31'h7FFF_FFFF; op_sub = 1'b0;
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        chk("sext_sum", os[1], 36'h8_0000_0004);
        chk("zext_sum", os[0], 36'h0_8000_0004);
        repeat (2) cycle();

        // Streaming with a 4-cycle stall after the first result
        idx = 0;
        stall_left = 0;
        stall_started = 1'b0;
        got.delete();
        for (int c = 0; c < 40 && got.size() < 5; c++) begin
            in_valid = (idx < 5);
            in_a = 35'(idx);
            in_b = 31'(idx);
            op_sub = 1'b0;
            out_ready = (stall_left == 0);
            #1;
            if (stall_left > 0) begin
                chk("stall_sum", os[0], held);
                chk("stall_in_ready", 36'(ir[0]), 36'd0);
            end
            acc = !mv[0][2] || out_ready;
            if (ov[0] && out_ready) got.push_back(os[0]);
            cycle();
            if (acc && in_valid) idx++;
            if (stall_left > 0) stall_left--;
            else if (!stall_started && ov[0]) begin
                stall_started = 1'b1;
                stall_left = 4;
                held = os[0];
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", 36'(got.size()), 36'd5);
        for (int i = 0; i < got.size(); i++)
            chk("stream_order", got[i], 36'(2 * i));
        repeat (3) cycle();

        // Randomised traffic with random backpressure
        for (int n = 0; n < 120; n++) begin
            in_valid = 1'($urandom());
            out_ready = ($urandom_range(0, 3) != 0);
            drive_rand();
            cycle();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) cycle();

        // Reset while two transactions are in flight
        in_valid = 1'b1;
        drive_rand();
        cycle();
        drive_rand();
        cycle();
        in_valid = 1'b0;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("midrst_valid", 36'(ov[0]), 36'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
